// File: rtl/ov7670_pkg.sv
// Shared encodings and constants for the OV7670 SCCB configuration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ov7670_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DELAY     = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } seq_state_t;

  // Pseudo-addresses that are not real OV7670 registers
  localparam logic [7:0] ADDR_END   = 8'hFF;
  localparam logic [7:0] ADDR_DELAY = 8'hF0;

  // COM7 with the software-reset bit set
  localparam logic [7:0] COM7       = 8'h12;
  localparam logic [7:0] COM7_RESET = 8'h80;

  // One table entry: register address then register value
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } rom_entry_t;

endpackage

// File: rtl/ov7670_config_seq_if.sv
// Write-command channel between the config sequencer and the SCCB master.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; cmd_done/cmd_nack report completion.
interface ov7670_config_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_done;
  logic       cmd_nack;

  modport master (
    output cmd_valid, cmd_addr, cmd_data,
    input  cmd_ready, cmd_done, cmd_nack
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data,
    output cmd_ready, cmd_done, cmd_nack
  );
endinterface

// File: rtl/ov7670_reg_rom.sv
// Register table of {addr, data} pairs: COM7 reset, 1 ms settle, register set, end marker.
// Latency: 1 pclk (synchronous read).
// Backpressure: none; a new address may be presented every cycle.
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             pclk,
  input  logic [IDX_W-1:0] rd_addr,
  output rom_entry_t       rd_data
);

  function automatic rom_entry_t rom_lookup(input logic [IDX_W-1:0] idx);
    rom_entry_t e;
    case (int'(idx))
      0:       e = {COM7, COM7_RESET};   // software reset
      1:       e = {ADDR_DELAY, 8'h01};  // 1 ms settle after reset
      2:       e = {8'h11, 8'h01};       // CLKRC: prescale by 2
      3:       e = {8'h3A, 8'h04};       // TSLB: output sequence
      4:       e = {8'h12, 8'h04};       // COM7: RGB output
      5:       e = {8'h40, 8'hD0};       // COM15: RGB565, full range
      6:       e = {8'h8C, 8'h00};       // RGB444 disabled
      7:       e = {8'h3E, 8'h00};       // COM14: no scaling
      default: e = {ADDR_END, 8'hFF};    // end of table
    endcase
    return e;
  endfunction

  // Registered table read
  always_ff @(posedge pclk) begin
    rd_data <= rom_lookup(rd_addr);
  end

endmodule

// File: rtl/ov7670_config_seq.sv
// Walks the register table and writes each entry to the SCCB master, then raises setup_complete.
// Latency: 4 pclk per register plus master latency; delay entries cost data ms.
// Backpressure: holds cmd_valid/addr/data until cmd_ready; retries NACKed writes up to MAX_RETRIES.
module ov7670_config_seq
  import ov7670_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 24000000,
  parameter int TABLE_DEPTH = 256,
  parameter int MAX_RETRIES = 3,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic                       start,
  ov7670_config_seq_if.master        cmd,
  output logic                       busy,
  output logic                       setup_complete,
  output logic                       error,
  output logic [7:0]                 entry_index
);

  localparam int IDX_W    = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam int PRESC_TC = CLK_FREQ_HZ / 1000 - 1;
  localparam int PRESC_W  = (PRESC_TC > 0) ? $clog2(PRESC_TC + 1) : 1;
  localparam int RETRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  seq_state_t         state;
  logic [IDX_W-1:0]   idx;
  logic [RETRY_W-1:0] retry_cnt;
  logic [PRESC_W-1:0] presc;
  logic [7:0]         ms_cnt;
  rom_entry_t         rom_q;
  logic               idx_last;

  ov7670_reg_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .pclk    (pclk),
    .rd_addr (idx),
    .rd_data (rom_q)
  );

  // The last table slot ends the run even without a terminator; the index never wraps
  assign idx_last    = (idx == IDX_W'(TABLE_DEPTH - 1));
  assign entry_index = 8'(idx);

  // Sequencer FSM with registered outputs
  always_ff @(posedge pclk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cmd.cmd_valid  <= 1'b0;
      cmd.cmd_addr   <= 8'h00;
      cmd.cmd_data   <= 8'h00;
      busy           <= 1'b0;
      setup_complete <= 1'b0;
      error          <= 1'b0;
      idx            <= '0;
      retry_cnt      <= '0;
      presc          <= '0;
      ms_cnt         <= 8'h00;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start || (state == ST_IDLE && AUTO_START)) begin
            state          <= ST_FETCH;
            idx            <= '0;
            retry_cnt      <= '0;
            busy           <= 1'b1;
            setup_complete <= 1'b0;
            error          <= 1'b0;
          end
        end
        ST_FETCH: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (rom_q.addr == ADDR_END) begin
            state          <= ST_DONE;
            busy           <= 1'b0;
            setup_complete <= 1'b1;
          end else if (rom_q.addr == ADDR_DELAY) begin
            ms_cnt <= rom_q.data;
            presc  <= '0;
            state  <= ST_DELAY;
          end else begin
            cmd.cmd_addr  <= rom_q.addr;
            cmd.cmd_data  <= rom_q.data;
            cmd.cmd_valid <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            state         <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (cmd.cmd_done) begin
            if (!cmd.cmd_nack) begin
              retry_cnt <= '0;
              if (idx_last) begin
                state          <= ST_DONE;
                busy           <= 1'b0;
                setup_complete <= 1'b1;
              end else begin
                idx   <= idx + 1'b1;
                state <= ST_FETCH;
              end
            end else if ((int'(retry_cnt) + 1) < MAX_RETRIES) begin
              retry_cnt     <= retry_cnt + 1'b1;
              cmd.cmd_valid <= 1'b1;
              state         <= ST_ISSUE;
            end else begin
              state          <= ST_ERROR;
              busy           <= 1'b0;
              error          <= 1'b1;
              setup_complete <= 1'b0;
            end
          end
        end
        ST_DELAY: begin
          if (ms_cnt == 8'h00) begin
            if (idx_last) begin
              state          <= ST_DONE;
              busy           <= 1'b0;
              setup_complete <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_FETCH;
            end
          end else if (presc == PRESC_W'(PRESC_TC)) begin
            presc  <= '0;
            ms_cnt <= ms_cnt - 8'h01;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench for ov7670_config_seq with a behavioural SCCB master.
// Latency: master answers cmd_done 10 pclk after each accept.
// Backpressure: master can stall cmd_ready and NACK selected writes.
module tb_ov7670_config_seq;

  logic       pclk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       setup_complete;
  logic       error;
  logic [7:0] entry_index;

  ov7670_config_seq_if bus ();

  ov7670_config_seq #(
    .CLK_FREQ_HZ (24000000),
    .TABLE_DEPTH (256),
    .MAX_RETRIES (3),
    .AUTO_START  (1'b1)
  ) dut (
    .pclk           (pclk),
    .reset          (reset),
    .start          (start),
    .cmd            (bus),
    .busy           (busy),
    .setup_complete (setup_complete),
    .error          (error),
    .entry_index    (entry_index)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Master configuration, written only by the stimulus block
  int         cfg_gen = 0;
  logic [7:0] nack_addr = 8'h00;
  int         nack_budget = 0;
  logic [7:0] stall_addr = 8'h00;
  bit         stall_en = 1'b0;
  bit         stray_tog = 1'b0;

  // Master state and logs, written only by the master process
  int         bfm_gen = 0;
  int         bfm_cnt = 0;
  int         nack_used = 0;
  int         stall_seen = 0;
  int         stall_glitch = 0;
  bit         stall_over = 1'b0;
  bit         stray_seen = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  logic [7:0] stall_a = 8'h00;
  logic [7:0] stall_d = 8'h00;
  int         last_done_cyc = 0;
  logic [7:0] acc_addr_q [$];
  logic [7:0] acc_data_q [$];
  int         acc_cyc_q  [$];

  // Behavioural SCCB master, driven on the falling edge
  always @(negedge pclk) begin
    bus.cmd_done = 1'b0;
    bus.cmd_nack = 1'b0;
    if (cfg_gen != bfm_gen) begin
      bfm_gen      = cfg_gen;
      nack_used    = 0;
      stall_seen   = 0;
      stall_glitch = 0;
      stall_over   = 1'b0;
    end
    if (!reset) begin
      bfm_cnt       = 0;
      bus.cmd_ready = 1'b1;
    end else begin
      if (stray_tog != stray_seen) begin
        stray_seen   = stray_tog;
        bus.cmd_done = 1'b1;
      end
      if (bfm_cnt > 0) begin
        bfm_cnt--;
        if (bfm_cnt == 0) begin
          bus.cmd_done  = 1'b1;
          last_done_cyc = cyc + 1;
          if (pend_addr == nack_addr && nack_used < nack_budget) begin
            bus.cmd_nack = 1'b1;
            nack_used++;
          end
        end
      end
      bus.cmd_ready = 1'b1;
      if (stall_en && !stall_over && bus.cmd_valid === 1'b1 && bus.cmd_addr == stall_addr) begin
        if (stall_seen == 0) begin
          stall_a = bus.cmd_addr;
          stall_d = bus.cmd_data;
        end
        if (stall_seen < 50) begin
          bus.cmd_ready = 1'b0;
          stall_seen++;
          if (bus.cmd_addr != stall_a || bus.cmd_data != stall_d) stall_glitch++;
        end else begin
          stall_over = 1'b1;
        end
      end
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready) begin
        acc_addr_q.push_back(bus.cmd_addr);
        acc_data_q.push_back(bus.cmd_data);
        acc_cyc_q.push_back(cyc + 1);
        pend_addr = bus.cmd_addr;
        bfm_cnt   = 10;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.cmd_valid), 32'd0);
    check({tag, "_addr"},  32'(bus.cmd_addr),  32'h00);
    check({tag, "_data"},  32'(bus.cmd_data),  32'h00);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_setup"}, 32'(setup_complete), 32'd0);
    check({tag, "_error"}, 32'(error),         32'd0);
    check({tag, "_index"}, 32'(entry_index),   32'd0);
  endtask

  task automatic wait_accepts(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && acc_addr_q.size() < n; k++) tick();
    check(tag, 32'(acc_addr_q.size() >= n), 32'd1);
  endtask

  // Hand-written copy of the expected table, {addr, data}
  logic [15:0] exp_tab [0:8] = '{16'h1280, 16'hF001, 16'h1101, 16'h3A04, 16'h1204,
                                 16'h40D0, 16'h8C00, 16'h3E00, 16'hFFFF};
  int          run1_seq [0:8] = '{0, 2, 3, 3, 3, 4, 5, 6, 7};

  initial begin
    int base;
    int setup_cyc;
    int gap;
    logic [15:0] e;

    // Reset state
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Run 1: stall entry 2 for 50 cycles, NACK entry 3 twice
    nack_addr   = 8'h3A;
    nack_budget = 2;
    stall_addr  = 8'h11;
    stall_en    = 1'b1;
    cfg_gen++;
    base = acc_addr_q.size();
    reset = 1'b1;
    tick();
    check("autostart_busy", 32'(busy), 32'd1);
    wait_accepts(base + 1, 50, "first_accept_timeout");
    check("first_addr", 32'(acc_addr_q[base]), 32'h12);
    check("first_data", 32'(acc_data_q[base]), 32'h80);

    // start while busy (inside the settle delay) is ignored
    repeat (100) tick();
    check("delay_index", 32'(entry_index), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_index", 32'(entry_index), 32'd1);
    check("busy_start_busy", 32'(busy), 32'd1);

    setup_cyc = 0;
    for (int k = 0; k < 30000 && !setup_complete; k++) tick();
    setup_cyc = cyc;
    check("run1_done_timeout", 32'(setup_complete), 32'd1);
    check("setup_lag", 32'(setup_cyc - last_done_cyc), 32'd2);
    check("run1_busy", 32'(busy), 32'd0);
    check("run1_error", 32'(error), 32'd0);
    check("run1_index", 32'(entry_index), 32'd8);
    check("run1_accepts", 32'(acc_addr_q.size() - base), 32'd9);
    if (acc_addr_q.size() - base >= 9) begin
      for (int i = 0; i < 9; i++) begin
        e = exp_tab[run1_seq[i]];
        check($sformatf("run1_addr%0d", i), 32'(acc_addr_q[base + i]), 32'(e[15:8]));
        check($sformatf("run1_data%0d", i), 32'(acc_data_q[base + i]), 32'(e[7:0]));
      end
      gap = acc_cyc_q[base + 1] - acc_cyc_q[base];
      check("delay_gap_24000", 32'(gap >= 24000 && gap <= 24100), 32'd1);
    end
    check("stall_cycles", 32'(stall_seen), 32'd50);
    check("stall_stable", 32'(stall_glitch), 32'd0);

    // Run 2: restart from DONE, entry 3 NACKed three times
    nack_budget = 3;
    stall_en    = 1'b0;
    cfg_gen++;
    base = acc_addr_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_restart_setup", 32'(setup_complete), 32'd0);
    check("done_restart_busy", 32'(busy), 32'd1);
    check("done_restart_index", 32'(entry_index), 32'd0);
    for (int k = 0; k < 30000 && !error; k++) tick();
    check("run2_error", 32'(error), 32'd1);
    check("run2_busy", 32'(busy), 32'd0);
    check("run2_setup", 32'(setup_complete), 32'd0);
    check("run2_index", 32'(entry_index), 32'd3);
    check("run2_valid", 32'(bus.cmd_valid), 32'd0);
    check("run2_accepts", 32'(acc_addr_q.size() - base), 32'd5);
    if (acc_addr_q.size() - base >= 5) begin
      check("run2_entry0_addr", 32'(acc_addr_q[base]), 32'h12);
      check("run2_last_addr", 32'(acc_addr_q[base + 4]), 32'h3A);
      check("run2_last_data", 32'(acc_data_q[base + 4]), 32'h04);
    end
    repeat (20) tick();
    check("error_hold_index", 32'(entry_index), 32'd3);
    check("error_hold", 32'(error), 32'd1);

    // Run 3: restart from ERROR, then reset while waiting for done
    nack_budget = 0;
    cfg_gen++;
    base = acc_addr_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_restart_error", 32'(error), 32'd0);
    check("err_restart_busy", 32'(busy), 32'd1);
    wait_accepts(base + 1, 20, "run3_accept_timeout");
    if (acc_addr_q.size() > base) begin
      check("run3_addr", 32'(acc_addr_q[base]), 32'h12);
      check("run3_data", 32'(acc_data_q[base]), 32'h80);
    end
    repeat (3) tick();
    check("wait_done_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    check_reset_outputs("midreset");
    tick();
    reset = 1'b1;
    stray_tog = ~stray_tog;
    base = acc_addr_q.size();
    wait_accepts(base + 1, 20, "rerun_accept_timeout");
    if (acc_addr_q.size() > base) begin
      check("rerun_addr", 32'(acc_addr_q[base]), 32'h12);
      check("rerun_data", 32'(acc_data_q[base]), 32'h80);
    end
    check("rerun_index0", 32'(entry_index), 32'd0);
    for (int k = 0; k < 30 && entry_index != 8'd1; k++) tick();
    check("rerun_index1", 32'(entry_index), 32'd1);
    check("rerun_busy", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
